// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM self-test sequencer.
// Optional build macro: SDRAM_TEST_LFSR_EN selects the LFSR data pattern
// instead of the default incrementing-counter pattern.
package sdram_test_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        WRITE     = 3'd1,
        GAP       = 3'd2,
        READ      = 3'd3,
        CHECK     = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Starting pattern value for a pass, derived from the pass counter so
    // every pass writes different data.
    function automatic logic [DATA_W-1:0] pat_seed(input logic [DATA_W-1:0] pass);
`ifdef SDRAM_TEST_LFSR_EN
        logic [DATA_W-1:0] s;
        s = LFSR_SEED ^ pass;
        // An all-zero LFSR would lock up, so zero falls back to the base seed.
        return (s == '0) ? LFSR_SEED : s;
`else
        return pass;
`endif
    endfunction

    // Next pattern value after one word.
    function automatic logic [DATA_W-1:0] pat_step(input logic [DATA_W-1:0] v);
`ifdef SDRAM_TEST_LFSR_EN
        // Fibonacci LFSR, taps for x^16 + x^14 + x^13 + x^11 + 1.
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[DATA_W-1:1]};
`else
        return v + DATA_W'(1);
`endif
    endfunction

endpackage

// File: rtl/sdram_pat_gen.sv
// Test-pattern generator: load a seed, then advance one word per step.
// Used once for the write stream and once to regenerate the expected read
// stream, so no copy of the written block has to be kept.
// Optional build macro: SDRAM_TEST_LFSR_EN (via the pattern functions).
module sdram_pat_gen
    import sdram_test_pkg::*;
(
    input  logic              clk_50m,
    input  logic              sys_rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] pat
);

    logic [DATA_W-1:0] pat_reg;

    // Pattern register: load has priority over step.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_reg <= '0;
        end else if (load) begin
            pat_reg <= seed;
        end else if (step) begin
            pat_reg <= pat_step(pat_reg);
        end
    end

    assign pat = pat_reg;

endmodule

// File: rtl/sdram_test_seq.sv
// Self-checking SDRAM test sequencer: writes a block of DEPTH words through
// the controller's write FIFO, waits GAP_CYC cycles, reads the block back and
// compares it against a regenerated pattern, then repeats.
// Optional build macro: SDRAM_TEST_LFSR_EN (LFSR data pattern).
module sdram_test_seq
    import sdram_test_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned GAP_CYC = 2048,
    parameter bit          LOOP_EN = 1'b1
) (
    input  logic              clk_50m,
    input  logic              sys_rst_n,
    input  logic              sdram_init_done,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              error_flag,
    output logic [DATA_W-1:0] err_cnt,
    output logic [DATA_W-1:0] pass_cnt,
    output logic [DATA_W-1:0] last_rd
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic              init_meta_reg, init_sync_reg;
    logic              cmp_v_reg;
    logic [DATA_W-1:0] exp_reg;
    logic              error_flag_reg;
    logic [DATA_W-1:0] err_cnt_reg, pass_cnt_reg, last_rd_reg;
    logic [DATA_W-1:0] pass_cnt_next;
    logic              pass_inc;
    logic [DATA_W-1:0] wr_pat, rd_pat;

    // Bring init_done over from the controller clock domain.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            init_meta_reg <= 1'b0;
            init_sync_reg <= 1'b0;
        end else begin
            init_meta_reg <= sdram_init_done;
            init_sync_reg <= init_meta_reg;
        end
    end

    // Sequencer state and phase counters.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= WAIT_INIT;
            idx_reg   <= '0;
            gap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            gap_reg   <= gap_next;
        end
    end

    // Next-state and strobe decode. Losing init_done in any active phase
    // aborts to WAIT_INIT; the FIFO strobes are gated in that cycle so no
    // partial word is issued.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        gap_next   = gap_reg;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            WAIT_INIT: begin
                idx_next = '0;
                gap_next = '0;
                if (init_sync_reg) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (!init_sync_reg) begin
                    state_next = WAIT_INIT;
                    idx_next   = '0;
                end else begin
                    wr_en = 1'b1;
                    if (idx_reg == IDX_W'(DEPTH - 1)) begin
                        idx_next   = '0;
                        state_next = GAP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            GAP: begin
                busy = 1'b1;
                if (!init_sync_reg) begin
                    state_next = WAIT_INIT;
                    gap_next   = '0;
                end else if (gap_reg == GAP_W'(GAP_CYC - 1)) begin
                    gap_next   = '0;
                    state_next = READ;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            READ: begin
                busy = 1'b1;
                if (!init_sync_reg) begin
                    state_next = WAIT_INIT;
                    idx_next   = '0;
                end else begin
                    rd_en = 1'b1;
                    if (idx_reg == IDX_W'(DEPTH - 1)) begin
                        idx_next   = '0;
                        state_next = CHECK;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (!init_sync_reg) begin
                    state_next = WAIT_INIT;
                end else begin
                    state_next = LOOP_EN ? WRITE : DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = WAIT_INIT;
            end
        endcase
    end

    assign pass_inc      = (state_reg == CHECK) && init_sync_reg;
    assign pass_cnt_next = pass_inc ? pass_cnt_reg + DATA_W'(1) : pass_cnt_reg;

    // Write-side pattern: held at the seed of the upcoming pass whenever not
    // writing, so the first WRITE cycle already presents pattern(0).
    sdram_pat_gen u_wr_gen (
        .clk_50m   (clk_50m),
        .sys_rst_n (sys_rst_n),
        .load      (state_reg != WRITE),
        .step      (wr_en),
        .seed      (pat_seed(pass_cnt_next)),
        .pat       (wr_pat)
    );

    // Read-side pattern: regenerates the same sequence from the same seed.
    sdram_pat_gen u_rd_gen (
        .clk_50m   (clk_50m),
        .sys_rst_n (sys_rst_n),
        .load      (state_reg != READ),
        .step      (rd_en),
        .seed      (pat_seed(pass_cnt_reg)),
        .pat       (rd_pat)
    );

    // Compare pipeline: read data arrives one cycle after rd_en, so the
    // expected word and a valid strobe are delayed to line up with it.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmp_v_reg      <= 1'b0;
            exp_reg        <= '0;
            error_flag_reg <= 1'b0;
            err_cnt_reg    <= '0;
            last_rd_reg    <= '0;
        end else begin
            cmp_v_reg <= rd_en;
            exp_reg   <= rd_pat;
            if (cmp_v_reg) begin
                last_rd_reg <= rd_data;
                if (rd_data != exp_reg) begin
                    error_flag_reg <= 1'b1;
                    if (err_cnt_reg != {DATA_W{1'b1}}) begin
                        err_cnt_reg <= err_cnt_reg + DATA_W'(1);
                    end
                end
            end
        end
    end

    // Completed-pass counter, wraps naturally.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pass_cnt_reg <= '0;
        end else begin
            pass_cnt_reg <= pass_cnt_next;
        end
    end

    assign wr_data    = wr_en ? wr_pat : '0;
    assign error_flag = error_flag_reg;
    assign err_cnt    = err_cnt_reg;
    assign pass_cnt   = pass_cnt_reg;
    assign last_rd    = last_rd_reg;

endmodule
